// File: rtl/leg_uart_pkg.sv
// Shared UART types and constants: transmit FSM state encoding,
// default baud divisor and the idle line level.
package leg_uart_pkg;

    // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Mark level of an idle async serial line
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and flags the terminal count with a
// combinational one-cycle tick; a synchronous clear restarts the period.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear to count 0
//   tick_c  - high while the counter sits at its terminal count
module uart_baud_tick
    import leg_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = (count == TERMINAL);

    // Wraps at terminal count so consecutive bits of one state line up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains the CPU TX FIFO.
// Pops one word whenever idle and the FIFO is non-empty, then sends it as
// start bit, DATA_WIDTH data bits LSB first, optional even parity bit,
// and STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data and stop bits.
// Ports:
//   i_clk          - system clock, rising edge
//   i_rst          - asynchronous reset, active low
//   i_fifo_data    - FIFO read data, valid the cycle after a pop
//   i_fifo_empty   - FIFO empty flag
//   o_fifo_read_en - combinational pop strobe (IDLE and FIFO non-empty)
//   o_tx           - registered serial line, idle high
//   o_busy         - registered, high whenever not IDLE
module uart_tx_drain
    import leg_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_read_en,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] shift, shift_d;
    logic [IDX_W-1:0]      bit_idx, bit_idx_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  bit_done_c;
    logic                  baud_clear_c;
`ifdef UART_TX_PARITY_EN
    logic                  parity, parity_d;
`endif

    // Bit timing; restarts on every state change
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clear  (baud_clear_c),
        .tick_c (bit_done_c)
    );

    assign o_fifo_read_en = (state == IDLE) && !i_fifo_empty;
    assign baud_clear_c   = (state_d != state);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_idx_d = bit_idx;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity;
`endif
        tx_d      = UART_IDLE_LEVEL;
        busy_d    = 1'b0;

        case (state)
            IDLE: begin
                if (!i_fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d   = i_fifo_data;
                bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^i_fifo_data;
`endif
                state_d   = START;
            end
            START: begin
                if (bit_done_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    shift_d = shift >> 1;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done_c) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // bit_idx reused to count stop bits
                if (bit_done_c) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level decoded from the next state so o_tx lines up with state
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // State and output registers; reset drops the line high at once
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            o_tx    <= UART_IDLE_LEVEL;
            o_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_idx <= bit_idx_d;
            o_tx    <= tx_d;
            o_busy  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain (CLKS_PER_BIT=4, 8N1).
// A behavioural FIFO feeds the DUT; a frame-level model predicts line,
// busy and pop strobe every cycle; a line decoder recovers bytes for
// literal checks. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int DW  = 8;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
    localparam logic [11:0] A5_FRAME = 12'b0101_0100_1010;
`else
    localparam int PB  = 0;
    localparam logic [11:0] A5_FRAME = 12'b0011_0100_1010;
`endif
    localparam int FRAME_BITS = 1 + DW + PB + SB;
    localparam int PERIOD     = FRAME_BITS * CPB + 2;

    logic          i_clk        = 1'b0;
    logic          i_rst        = 1'b0;
    logic [DW-1:0] i_fifo_data  = '0;
    logic          i_fifo_empty = 1'b1;
    logic          o_fifo_read_en;
    logic          o_tx;
    logic          o_busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_words[$];
    logic [1:0]    plan[$];
    logic          pop_pend = 1'b0;

    int         cyc         = 0;
    int         rd_count    = 0;
    int         last_rd_cyc = -1;
    logic       rx_active   = 1'b0;
    int         rx_off      = 0;
    int         rx_start    = 0;
    logic [11:0] rx_frame   = '0;
    logic [DW-1:0] rx_bytes[$];
    int            rx_starts[$];
    logic [11:0]   rx_frames[$];

    logic [1:0]    m_e;
    logic [DW-1:0] m_w;
    logic          m_b;

    uart_tx_drain #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fifo_data    (i_fifo_data),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_read_en (o_fifo_read_en),
        .o_tx           (o_tx),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_words.push_back(w);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t;
        t = 0;
        while (rx_bytes.size() < n && t < budget) begin
            @(negedge i_clk);
            t++;
        end
        chk("wait_bytes_in_time", 64'(rx_bytes.size() >= n), 64'd1);
    endtask

    // FIFO: pop requested in the previous cycle lands just after the edge
    always @(posedge i_clk) begin
        #1;
        if (!i_rst) begin
            fifo_q.delete();
            i_fifo_empty = 1'b1;
        end else begin
            if (pop_pend) begin
                if (fifo_q.size() > 0) i_fifo_data = fifo_q.pop_front();
                else chk("pop_while_empty", 64'd1, 64'd0);
            end
            i_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Cycle counter, pop bookkeeping and line decoder (mid-bit sampling)
    always @(negedge i_clk) begin
        cyc++;
        pop_pend = i_rst && o_fifo_read_en;
        if (i_rst && o_fifo_read_en) begin
            rd_count++;
            last_rd_cyc = cyc;
        end
        if (!i_rst) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && o_tx == 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
                rx_start  = cyc;
                rx_frame  = '0;
            end else if (rx_active) begin
                rx_off++;
            end
            if (rx_active && (rx_off % CPB) == CPB / 2) begin
                rx_frame[rx_off / CPB] = o_tx;
                if (rx_off / CPB == FRAME_BITS - 1) begin
                    rx_active = 1'b0;
                    rx_bytes.push_back(rx_frame[DW:1]);
                    rx_starts.push_back(rx_start);
                    rx_frames.push_back(rx_frame);
                end
            end
        end
    end

    // Frame model: per-cycle {tx, busy} schedule built when a pop is due
    always @(negedge i_clk) begin
        if (!i_rst) begin
            plan.delete();
            exp_words.delete();
            chk("rst_tx", 64'(o_tx), 64'd1);
            chk("rst_busy", 64'(o_busy), 64'd0);
            chk("rst_read_en", 64'(o_fifo_read_en), 64'd0);
        end else if (plan.size() > 0) begin
            m_e = plan.pop_front();
            chk("frame_tx", 64'(o_tx), 64'(m_e[1]));
            chk("frame_busy", 64'(o_busy), 64'(m_e[0]));
            chk("frame_read_en", 64'(o_fifo_read_en), 64'd0);
        end else begin
            chk("idle_tx", 64'(o_tx), 64'd1);
            chk("idle_busy", 64'(o_busy), 64'd0);
            chk("idle_read_en", 64'(o_fifo_read_en), 64'(!i_fifo_empty));
            if (!i_fifo_empty) begin
                if (exp_words.size() == 0) begin
                    chk("model_word_available", 64'd0, 64'd1);
                    m_w = '0;
                end else begin
                    m_w = exp_words.pop_front();
                end
                plan.push_back(2'b11);
                for (int k = 0; k < FRAME_BITS; k++) begin
                    if (k == 0)                   m_b = 1'b0;
                    else if (k <= DW)             m_b = m_w[k-1];
                    else if (PB == 1 && k == DW + 1) m_b = ^m_w;
                    else                          m_b = 1'b1;
                    for (int c = 0; c < CPB; c++) plan.push_back({m_b, 1'b1});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        int base_b;
        int base_rd;
        int t;

        // Reset with empty FIFO, then 50 idle cycles
        repeat (3) @(negedge i_clk);
        chk("reset_tx_lit", 64'(o_tx), 64'd1);
        chk("reset_busy_lit", 64'(o_busy), 64'd0);
        #1 i_rst = 1'b1;
        repeat (50) @(negedge i_clk);
        chk("empty_no_pop", 64'(rd_count), 64'd0);
        chk("empty_busy", 64'(o_busy), 64'd0);
        chk("empty_tx", 64'(o_tx), 64'd1);

        // Single word 0xA5
        push(8'hA5);
        wait_bytes(1, 100);
        chk("a5_byte", 64'(rx_bytes[0]), 64'hA5);
        chk("a5_start_latency", 64'(rx_starts[0] - last_rd_cyc), 64'd2);
        chk("a5_line_pattern", 64'(rx_frames[0]), 64'(A5_FRAME));
        repeat (4) @(negedge i_clk);
        chk("a5_busy_after", 64'(o_busy), 64'd0);
        chk("a5_one_pop", 64'(rd_count), 64'd1);

        // Back-to-back 0x00, 0xFF
        base_b  = rx_bytes.size();
        base_rd = rd_count;
        @(negedge i_clk);
        push(8'h00);
        push(8'hFF);
        wait_bytes(base_b + 2, 3 * PERIOD);
        chk("b2b_first", 64'(rx_bytes[base_b]), 64'h00);
        chk("b2b_second", 64'(rx_bytes[base_b+1]), 64'hFF);
        chk("b2b_start_spacing", 64'(rx_starts[base_b+1] - rx_starts[base_b]), 64'(PERIOD));
        repeat (4) @(negedge i_clk);
        chk("b2b_two_pops", 64'(rd_count - base_rd), 64'd2);

        // Reset during data bit 3 of 0x3C
        repeat (5) @(negedge i_clk);
        base_b  = rx_bytes.size();
        base_rd = rd_count;
        push(8'h3C);
        t = 0;
        while (!rx_active && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        chk("rst_frame_started", 64'(rx_active), 64'd1);
        repeat (17) @(negedge i_clk);
        @(posedge i_clk);
        #2;
        chk("mid_busy_before_rst", 64'(o_busy), 64'd1);
        i_rst = 1'b0;
        #1;
        chk("async_rst_tx", 64'(o_tx), 64'd1);
        chk("async_rst_busy", 64'(o_busy), 64'd0);
        repeat (3) @(negedge i_clk);
        #1 i_rst = 1'b1;
        repeat (30) @(negedge i_clk);
        chk("rst_no_residual_frame", 64'(rx_bytes.size() - base_b), 64'd0);
        chk("rst_single_pop", 64'(rd_count - base_rd), 64'd1);
        chk("rst_idle_busy", 64'(o_busy), 64'd0);

        // Sixteen queued words 0x00..0x0F
        base_b  = rx_bytes.size();
        base_rd = rd_count;
        @(negedge i_clk);
        for (int i = 0; i < 16; i++) push(DW'(i));
        wait_bytes(base_b + 16, 16 * PERIOD + 100);
        for (int i = 0; i < 16; i++) chk("seq_byte", 64'(rx_bytes[base_b+i]), 64'(i));
        repeat (10) @(negedge i_clk);
        chk("seq_sixteen_pops", 64'(rd_count - base_rd), 64'd16);
        chk("seq_fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("seq_busy_after", 64'(o_busy), 64'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        base_b = rx_bytes.size();
        push(8'h07);
        wait_bytes(base_b + 1, 2 * PERIOD);
        chk("parity_07", 64'(rx_frames[base_b][DW+1]), 64'd1);
        repeat (4) @(negedge i_clk);
        push(8'h03);
        wait_bytes(base_b + 2, 2 * PERIOD);
        chk("parity_03", 64'(rx_frames[base_b+1][DW+1]), 64'd0);
        repeat (4) @(negedge i_clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
